uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Serial transmitter, 8N1 by default; the transmit-side companion to the board's UART receiver, driving the FPGA TX pin.
- Takes bytes from CPU/LED-controller logic over a valid/ready handshake and shifts them out LSB first at BAUD_RATE.
- One clock domain; no FIFO. The upstream module holds data until it is accepted.

Parameters:
- CLK_FRE, 50_000_000: clock frequency in Hz.
- BAUD_RATE, 57600: serial baud rate.
- STOP_BITS, 1: number of stop bits; legal values are 1 and 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- tx_data  input  8  byte to send; sampled only on the accept cycle.
- tx_data_valid  input  1  upstream holds a byte.
- tx_data_ready  output  1  transmitter can accept a byte.
- tx_pin  output  1  serial output; idles high.
- tx_busy  output  1  a frame is in progress.

Behaviour:
- Clocking and reset:
  - Single clock clk. rst is synchronous and active-high.
  - On rst: state=S_IDLE, tx_pin=1, tx_busy=0, tx_data_ready=1 (it follows state), counters=0, shift register=0.
- Bit timing:
  - CYCLE = CLK_FRE/BAUD_RATE (integer division).
  - cycle_cnt is 16 bit. An elaboration error is raised if CYCLE<2 or CYCLE>65535.
  - cycle_cnt counts 0..CYCLE-1 within each bit, then wraps to 0. It clears on every state change.
- Handshake:
  - tx_data_ready = (state==S_IDLE), decoded from the state register.
  - Accept occurs on a clock edge with tx_data_valid && tx_data_ready. At that edge tx_data is latched into tx_bits and state becomes S_START.
  - tx_data changes while not ready are ignored.
  - tx_data_valid must not depend combinationally on tx_data_ready.
- State machine (state_t):
  - S_IDLE: tx_pin=1. On accept, go to S_START.
  - S_START: tx_pin=0 for CYCLE clocks, then go to S_SEND_BYTE.
  - S_SEND_BYTE: tx_pin=tx_bits[bit_cnt] for CYCLE clocks per bit, bit_cnt 0..7. After bit 7 at cycle_cnt==CYCLE-1, go to S_STOP (or S_PARITY, see Optional Feature).
  - S_STOP: tx_pin=1 for STOP_BITS*CYCLE clocks, then go to S_IDLE.
- Output timing:
  - tx_pin is registered. The start-bit falling edge appears at the edge after the accept edge.
  - Each bit cell is exactly CYCLE clocks.
  - tx_busy=1 from the accept edge until the edge that returns the FSM to S_IDLE.
- Back-to-back frames:
  - Ready rises the cycle after stop completes.
  - With valid held high, the next start bit begins 1 clock after S_IDLE is entered, so the inter-frame gap is STOP_BITS*CYCLE+1 clocks high.
- bit_cnt is 3 bit. It increments at cycle_cnt==CYCLE-1 in S_SEND_BYTE and clears in all other states.
- Reset mid-frame: at the next edge tx_pin=1, state=S_IDLE, ready=1. The partial frame is dropped and the byte is not retransmitted.
- valid asserted during a frame: held off (ready=0). No loss, because upstream holds the byte.
- Illegal state encodings return to S_IDLE with tx_pin=1.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds state S_PARITY between S_SEND_BYTE and S_STOP.
  - Drives the even-parity bit (^tx_bits) for CYCLE clocks.
  - Frame length becomes (10+STOP_BITS)*CYCLE.
- Undefined:
  - S_PARITY is not generated; S_SEND_BYTE goes directly to S_STOP.
  - Frame length is (9+STOP_BITS)*CYCLE.
- The enum encoding is identical in both builds; S_PARITY is simply unreachable when undefined.

Decomposition:
- Package uart_pkg holds:
  - state_t (3-bit: S_IDLE=0, S_START=1, S_SEND_BYTE=2, S_STOP=3, S_PARITY=4);
  - function calc_cycle(clk_fre, baud) returning int;
  - localparam UART_DATA_BITS=8.
- Sub-module uart_baud_cnt, reusable by the receiver:
  - Inputs: clk, rst, clear.
  - Outputs: 16-bit cnt and a tick pulse when cnt==CYCLE-1.

Test Plan (CLK_FRE=1_000_000, BAUD_RATE=100_000, so CYCLE=10):
- After reset with idle inputs: tx_pin=1, ready=1, busy=0 for 100 clocks.
- Send 0x55, valid 1 clock: line is start(0), bits 1,0,1,0,1,0,1,0, stop(1), each exactly 10 clocks. Start falls 1 clock after accept. busy lasts 100 clocks.
- Send 0xA3 then 0x0F with valid held high: decoder recovers 0xA3, 0x0F. Gap between frames is 11 high clocks.
- Assert rst at clock 45 of a 0xFF frame: tx_pin=1 and ready=1 on the next edge; no further low bits.
- STOP_BITS=2, send 0x00: line low for 90 clocks, then high 20 clocks before ready returns.
- With UART_TX_PARITY_EN: 0x07 gives parity bit 1 and 0x03 gives parity bit 0, each 10 clocks before stop; frame is 110 clocks.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and timing helpers
// for the UART transmitter and its receiver companion.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_START     = 3'd1;
    localparam state_t S_SEND_BYTE = 3'd2;
    localparam state_t S_STOP      = 3'd3;
    localparam state_t S_PARITY    = 3'd4;

    function automatic int calc_cycle(input int clk_fre, input int baud);
        return clk_fre / baud;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: valid/ready byte handshake between upstream
// logic (master) and the UART transmitter (slave).
interface uart_tx_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] tx_data;
    logic                      tx_data_valid;
    logic                      tx_data_ready;

    modport master (
        output tx_data,
        output tx_data_valid,
        input  tx_data_ready
    );

    modport slave (
        input  tx_data,
        input  tx_data_valid,
        output tx_data_ready
    );

endinterface

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: per-bit cycle counter, 0..CYCLE-1 with a
// tick on the last cycle; shared by the UART TX and RX.
module uart_baud_cnt #(
    parameter int CYCLE = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    output logic [15:0] cnt_o,
    output logic        tick_o
);

    localparam logic [15:0] LAST = 16'(CYCLE - 1);

    logic [15:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST);
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (clear_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1/8N2 serial transmitter, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FRE   = 50_000_000,
    parameter int BAUD_RATE = 57600,
    parameter int STOP_BITS = 1
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave tx,
    output logic     tx_pin,
    output logic     tx_busy
);

    localparam int         CYCLE    = calc_cycle(CLK_FRE, BAUD_RATE);
    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    if (CYCLE < 2 || CYCLE > 65535) begin : g_bad_cycle
        $error("uart_tx: CLK_FRE/BAUD_RATE must be within 2..65535");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    state_t                    state_q, state_d;
    logic [UART_DATA_BITS-1:0] bits_q, bits_d;
    logic [2:0]                bit_cnt_q, bit_cnt_d;
    logic                      stop_cnt_q, stop_cnt_d;
    logic                      pin_q, pin_d;
    logic                      tick;
    logic                      accept;
    logic                      stop_done;
    logic [15:0]               cnt;
    logic                      unused_cnt;

    assign tx.tx_data_ready = (state_q == S_IDLE);
    assign accept    = tx.tx_data_valid && tx.tx_data_ready;
    assign stop_done = tick && (int'(stop_cnt_q) == STOP_BITS - 1);
    assign unused_cnt = ^cnt;

    // Restarting the bit timer on every state change keeps each
    // cell exactly CYCLE clocks regardless of idle history.
    uart_baud_cnt #(
        .CYCLE(CYCLE)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clear_i(state_d != state_q),
        .cnt_o  (cnt),
        .tick_o (tick)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:      if (accept) state_d = S_START;
            S_START:     if (tick) state_d = S_SEND_BYTE;
            S_SEND_BYTE: if (tick && bit_cnt_q == LAST_BIT)
`ifdef UART_TX_PARITY_EN
                             state_d = S_PARITY;
            S_PARITY:    if (tick) state_d = S_STOP;
`else
                             state_d = S_STOP;
`endif
            S_STOP:      if (stop_done) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bits_d     = accept ? tx.tx_data : bits_q;
        bit_cnt_d  = '0;
        stop_cnt_d = 1'b0;
        if (state_q == S_SEND_BYTE) begin
            bit_cnt_d = tick ? bit_cnt_q + 3'd1 : bit_cnt_q;
        end
        if (state_q == S_STOP) begin
            stop_cnt_d = tick ? ~stop_cnt_q : stop_cnt_q;
        end
        pin_d = 1'b1;
        unique case (state_q)
            S_START:     pin_d = 1'b0;
            S_SEND_BYTE: pin_d = bits_q[bit_cnt_q];
`ifdef UART_TX_PARITY_EN
            S_PARITY:    pin_d = ^bits_q;
`endif
            default:     pin_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            bits_q     <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            pin_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            bits_q     <= bits_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            pin_q      <= pin_d;
        end
    end

    assign tx_pin  = pin_q;
    assign tx_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: table vectors, hand sequences and random frames
// checked against a line-level model of the serial frame.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int CLK_FRE = 1_000_000;
    localparam int BAUD    = 100_000;
    localparam int CYC     = 10;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_if if1();
    uart_tx_if if2();
    logic pin1, busy1, pin2, busy2;

    uart_tx #(.CLK_FRE(CLK_FRE), .BAUD_RATE(BAUD), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .tx(if1), .tx_pin(pin1), .tx_busy(busy1)
    );
    uart_tx #(.CLK_FRE(CLK_FRE), .BAUD_RATE(BAUD), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .tx(if2), .tx_pin(pin2), .tx_busy(busy2)
    );

    typedef struct {
        bit         sel;
        logic [7:0] data;
        int         exp_low;
        int         exp_len;
    } vec_t;

    vec_t       vecs[7];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] bytes[$];
    logic       pin_q[$];
    logic       busy_q[$];
    logic       rdy_q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit s, input logic v, input logic [7:0] d);
        if (s) begin
            if2.tx_data_valid = v;
            if2.tx_data       = d;
        end else begin
            if1.tx_data_valid = v;
            if1.tx_data       = d;
        end
    endtask

    function automatic logic get_pin(input bit s);
        return s ? pin2 : pin1;
    endfunction
    function automatic logic get_busy(input bit s);
        return s ? busy2 : busy1;
    endfunction
    function automatic logic get_rdy(input bit s);
        return s ? if2.tx_data_ready : if1.tx_data_ready;
    endfunction

    function automatic int frame_len(input bit s);
        return (9 + (s ? 2 : 1) + PAR) * CYC;
    endfunction

    // cell i of a frame: start, 8 data LSB first, [parity], stop(s)
    function automatic logic line_bit(input logic [7:0] d, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return d[i-1];
        if (i == 9 && PAR == 1) return ^d;
        return 1'b1;
    endfunction

    task automatic run_seq(input bit s, input bit hold);
        int n, fl, gap, tend, pe, be, re, st, i, dend, gseen;
        logic ep, eb;
        logic [7:0] b;
        logic [7:0] dec[$];
        n    = bytes.size();
        fl   = frame_len(s);
        gap  = fl + 1;
        tend = (n - 1) * gap + fl + 2;
        pin_q.delete(); busy_q.delete(); rdy_q.delete();
        @(negedge clk);
        check("ready_before", int'(get_rdy(s)), 1);
        drive(s, 1'b1, bytes[0]);
        for (int t = 0; t <= tend; t++) begin
            @(negedge clk);
            pin_q.push_back(get_pin(s));
            busy_q.push_back(get_busy(s));
            rdy_q.push_back(get_rdy(s));
            for (int j = 0; j < n; j++) begin
                if (t == j * gap) begin
                    if (hold && j + 1 < n) drive(s, 1'b1, bytes[j+1]);
                    else drive(s, 1'b0, bytes[j]);
                end
            end
        end
        pe = 0; be = 0; re = 0;
        for (int t = 0; t <= tend; t++) begin
            ep = 1'b1;
            eb = 1'b0;
            for (int j = 0; j < n; j++) begin
                st = j * gap;
                if (t >= st && t < st + fl) eb = 1'b1;
                if (t > st && t <= st + fl) ep = line_bit(bytes[j], (t - st - 1) / CYC);
            end
            if (pin_q[t] !== ep) pe++;
            if (busy_q[t] !== eb) be++;
            if (rdy_q[t] !== !eb) re++;
        end
        check("line_wave", pe, 0);
        check("busy_wave", be, 0);
        check("ready_wave", re, 0);
        // receiver-style decode: find falling edge, sample mid-cell
        i = 0;
        while (i < pin_q.size()) begin
            if (pin_q[i] === 1'b0) begin
                for (int k = 0; k < 8; k++) b[k] = pin_q[i + (k + 1) * CYC + CYC / 2];
`ifdef UART_TX_PARITY_EN
                if (dec.size() < n)
                    check("parity_bit", int'(pin_q[i + 9 * CYC + CYC / 2]), int'(^bytes[dec.size()]));
`endif
                dec.push_back(b);
                i += (9 + PAR) * CYC;
            end else begin
                i++;
            end
        end
        check("frame_count", dec.size(), n);
        for (int j = 0; j < n && j < dec.size(); j++) check("decode", int'(dec[j]), int'(bytes[j]));
        if (n > 1) begin
            dend  = 1 + (9 + PAR) * CYC;
            gseen = 0;
            while (dend + gseen < pin_q.size() && pin_q[dend + gseen] !== 1'b0) gseen++;
            check("frame_gap", gseen, (s ? 2 : 1) * CYC + 1);
        end
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e, lows, bl, n;
        bit s;
        vecs[0] = '{1'b0, 8'h55, 50 + 10 * PAR, (10 + PAR) * CYC};
        vecs[1] = '{1'b0, 8'hFF, 10 + 10 * PAR, (10 + PAR) * CYC};
        vecs[2] = '{1'b0, 8'h00, 90 + 10 * PAR, (10 + PAR) * CYC};
        vecs[3] = '{1'b1, 8'h00, 90 + 10 * PAR, (11 + PAR) * CYC};
        vecs[4] = '{1'b0, 8'h07, 60,            (10 + PAR) * CYC};
        vecs[5] = '{1'b0, 8'h03, 70 + 10 * PAR, (10 + PAR) * CYC};
        vecs[6] = '{1'b1, 8'hA3, 50 + 10 * PAR, (11 + PAR) * CYC};

        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        e = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (pin1 !== 1'b1 || busy1 !== 1'b0 || if1.tx_data_ready !== 1'b1) e++;
            if (pin2 !== 1'b1 || busy2 !== 1'b0 || if2.tx_data_ready !== 1'b1) e++;
        end
        check("reset_idle", e, 0);

        for (int v = 0; v < 7; v++) begin
            bytes = {vecs[v].data};
            run_seq(vecs[v].sel, 1'b0);
            lows = 0;
            bl   = 0;
            foreach (pin_q[t]) if (pin_q[t] === 1'b0) lows++;
            foreach (busy_q[t]) if (busy_q[t] === 1'b1) bl++;
            check("vec_low", lows, vecs[v].exp_low);
            check("vec_len", bl, vecs[v].exp_len);
        end

        bytes = {8'hA3, 8'h0F};
        run_seq(1'b0, 1'b1);
        bytes = {8'h5A, 8'hC3};
        run_seq(1'b1, 1'b1);

        @(negedge clk);
        check("rst_ready_pre", int'(if1.tx_data_ready), 1);
        drive(1'b0, 1'b1, 8'hFF);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'hFF);
        repeat (44) @(negedge clk);
        check("rst_busy_mid", int'(busy1), 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_pin", int'(pin1), 1);
        check("rst_ready", int'(if1.tx_data_ready), 1);
        check("rst_busy", int'(busy1), 0);
        rst = 1'b0;
        e = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (pin1 !== 1'b1 || if1.tx_data_ready !== 1'b1) e++;
        end
        check("rst_no_retx", e, 0);

        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 3);
            s = 1'($urandom_range(0, 1));
            bytes.delete();
            for (int k = 0; k < n; k++) bytes.push_back(8'($urandom));
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_seq(s, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
